// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc, inst} pairs between fetch and decode.
// Optional macro FETCHQ_BYPASS_EN adds a zero-latency in->out path when the queue is empty.
module fetch_queue #(
    parameter int              DEPTH    = 2,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count_q;
    logic            stored_valid;
    logic            push;
    logic            pop;
    logic            bypass_take;
    logic            wr_en;
    logic            rd_en;

    assign stored_valid = (count_q != '0);
    // Registered-only: a pop while full never opens room for a push in the same cycle.
    assign in_ready     = (count_q != FULL);
    assign count        = count_q;

`ifdef FETCHQ_BYPASS_EN
    logic bypass;
    assign bypass      = ~stored_valid & in_valid & ~flush;
    assign bypass_take = bypass & out_ready;
`else
    assign bypass_take = 1'b0;
`endif

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        out_valid = stored_valid;
        out_pc    = pc_mem[rptr];
        out_inst  = inst_mem[rptr];
        if (!stored_valid) begin
            out_pc   = '0;
            out_inst = NOP_INST;
`ifdef FETCHQ_BYPASS_EN
            if (bypass) begin
                out_valid = 1'b1;
                out_pc    = in_pc;
                out_inst  = in_inst;
            end
`endif
        end
    end

    assign push  = in_valid & in_ready & ~flush;
    assign pop   = out_valid & out_ready & ~flush;
    // A bypassed entry is handed straight to decode and never touches storage.
    assign wr_en = push & ~bypass_take;
    assign rd_en = pop & ~bypass_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (rd_en) rptr <= rptr + AW'(1);
            if (wr_en && !rd_en)      count_q <= count_q + CW'(1);
            else if (rd_en && !wr_en) count_q <= count_q - CW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wptr]   <= in_pc;
            inst_mem[wptr] <= in_inst;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=2), plus streaming/bypass sequences.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        flush = 1'b0;
    logic [1:0]  count;

    int checks = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(2), .XLEN(32), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic [31:0] in_pc;
        logic [31:0] in_inst;
        logic        out_ready;
        logic        flush;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [1:0]  exp_count;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_pc = '0; in_inst = '0;
    endtask

    // Hold the vector across one rising edge, then idle the inputs so outputs reflect state only.
    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; in_valid = v.in_valid; in_pc = v.in_pc; in_inst = v.in_inst;
        out_ready = v.out_ready; flush = v.flush;
        @(posedge clk); #1;
        idle();
        #1;
        check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.exp_in_ready));
        check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_out_valid));
        check($sformatf("v%0d out_pc", idx), out_pc, v.exp_pc);
        check($sformatf("v%0d out_inst", idx), out_inst, v.exp_inst);
        check($sformatf("v%0d count", idx), 32'(count), 32'(v.exp_count));
    endtask

    vec_t vecs [18];

    initial begin
        //         rst  iv  in_pc        in_inst       ordy flush  ird ov  pc           inst          cnt
        vecs[0]  = '{1'b1, 1'b1, 32'h500, 32'h0000_0011, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   NOP,          2'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'h500, 32'h0000_0011, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   NOP,          2'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0050_0093, 2'd1};
        vecs[3]  = '{1'b0, 1'b1, 32'h104, 32'h00A0_0113, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0050_0093, 2'd2};
        vecs[4]  = '{1'b0, 1'b1, 32'h108, 32'h00F0_0193, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0050_0093, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h00A0_0113, 2'd1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   NOP,          2'd0};
        vecs[7]  = '{1'b0, 1'b1, 32'h110, 32'hAAAA_0001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h110, 32'hAAAA_0001, 2'd1};
        vecs[8]  = '{1'b0, 1'b1, 32'h114, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, 1'b1, 32'h110, 32'hAAAA_0001, 2'd2};
        // full + pop + offered push: only the pop happens
        vecs[9]  = '{1'b0, 1'b1, 32'h118, 32'hCCCC_0003, 1'b1, 1'b0, 1'b1, 1'b1, 32'h114, 32'hBBBB_0002, 2'd1};
        vecs[10] = '{1'b0, 1'b1, 32'h118, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0, 1'b1, 32'h114, 32'hBBBB_0002, 2'd2};
        // flush from full with a push and pop offered
        vecs[11] = '{1'b0, 1'b1, 32'h300, 32'hDDDD_0004, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   NOP,          2'd0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   NOP,          2'd0};
        vecs[13] = '{1'b0, 1'b1, 32'h120, 32'h1111_0005, 1'b0, 1'b0, 1'b1, 1'b1, 32'h120, 32'h1111_0005, 2'd1};
        // simultaneous push and pop at count=1
        vecs[14] = '{1'b0, 1'b1, 32'h124, 32'h2222_0006, 1'b1, 1'b0, 1'b1, 1'b1, 32'h124, 32'h2222_0006, 2'd1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   NOP,          2'd0};
        vecs[16] = '{1'b0, 1'b1, 32'h130, 32'h3333_0007, 1'b0, 1'b0, 1'b1, 1'b1, 32'h130, 32'h3333_0007, 2'd1};
        // reset overrides handshakes
        vecs[17] = '{1'b1, 1'b1, 32'h134, 32'h4444_0008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   NOP,          2'd0};

        @(posedge clk); #1;
        for (int i = 0; i < 18; i++) apply(vecs[i], i);

        // Streaming: in_valid and out_ready held high, pc += 4 from 0x200.
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_pc = 32'h200 + 32'(4 * k);
            in_inst = 32'h1000 + in_pc;
            #1;
`ifdef FETCHQ_BYPASS_EN
            check($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stream%0d out_pc", k), out_pc, 32'h200 + 32'(4 * k));
            check($sformatf("stream%0d count", k), 32'(count), 32'd0);
`else
            if (k == 0) begin
                check("stream0 out_valid", 32'(out_valid), 32'd0);
                check("stream0 count", 32'(count), 32'd0);
            end else begin
                check($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
                check($sformatf("stream%0d out_pc", k), out_pc, 32'h200 + 32'(4 * (k - 1)));
                check($sformatf("stream%0d out_inst", k), out_inst, 32'h1200 + 32'(4 * (k - 1)));
                check($sformatf("stream%0d count", k), 32'(count), 32'd1);
            end
`endif
            @(posedge clk); #1;
        end
        idle();
        flush = 1'b1;
        @(posedge clk); #1;
        idle();
        #1;
        check("post-stream flush count", 32'(count), 32'd0);

        // Empty queue, entry offered with decode ready.
        in_valid = 1'b1; in_pc = 32'h400; in_inst = 32'hFE01_0113; out_ready = 1'b1;
        #1;
`ifdef FETCHQ_BYPASS_EN
        check("bypass out_valid", 32'(out_valid), 32'd1);
        check("bypass out_pc", out_pc, 32'h400);
        check("bypass out_inst", out_inst, 32'hFE01_0113);
        @(posedge clk); #1;
        idle(); #1;
        check("bypass consumed count", 32'(count), 32'd0);
        check("bypass consumed out_valid", 32'(out_valid), 32'd0);
`else
        check("no-bypass out_valid", 32'(out_valid), 32'd0);
        check("no-bypass out_pc", out_pc, 32'h0);
        check("no-bypass out_inst", out_inst, NOP);
        @(posedge clk); #1;
        idle(); #1;
        check("no-bypass stored count", 32'(count), 32'd1);
        check("no-bypass stored out_pc", out_pc, 32'h400);
`endif

        // Empty queue, entry offered while decode stalls: must be stored in either build.
        flush = 1'b1;
        @(posedge clk); #1;
        idle();
        in_valid = 1'b1; in_pc = 32'h404; in_inst = 32'h0000_0513; out_ready = 1'b0;
        @(posedge clk); #1;
        idle(); #1;
        check("stall store count", 32'(count), 32'd1);
        check("stall store out_pc", out_pc, 32'h404);
        check("stall store out_inst", out_inst, 32'h0000_0513);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
